slave_fifo_responder: RTL and testbench

- Cycle-accurate, synthesizable stand-in for the USB controller's slave-FIFO side, used for loopback builds and bench stimulus.
- Responds to the FPGA-side master signals (SLOE, SLRD, SLWR, FIFOADR, PKTEND, FD) exactly as the message reader/writer expects.
- Owns two buffers: an OUT FIFO (host→FPGA, address 2'b00) and an IN FIFO (FPGA→host, address 2'b10).
- Exposes a simple host port for injecting OUT words and draining committed IN words.

---
 rtl/slave_fifo_responder_pkg.sv | 5 +
 rtl/slave_fifo_responder_sync_fifo_w16.sv | 46 ++++
 rtl/slave_fifo_responder.sv | 103 ++++++++++
 tb/tb_slave_fifo_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/slave_fifo_responder_pkg.sv
// Shared endpoint addresses for the slave-FIFO responder and the FPGA-side reader/writer.
package slave_fifo_responder_pkg;
  localparam logic [1:0] SLFIFO_ADR_OUT = 2'b00;
  localparam logic [1:0] SLFIFO_ADR_IN  = 2'b10;
endpackage

// File: rtl/slave_fifo_responder_sync_fifo_w16.sv
// sync_fifo_w16: 16-bit single-clock FIFO with occupancy count; head word read straight from storage.
module sync_fifo_w16 #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [15:0]           push_data,
  input  logic                  pop,
  output logic [15:0]           head,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/slave_fifo_responder.sv
// Slave-FIFO responder: OUT/IN buffers, packet commit, FD tristate and flags.
// Optional protocol checker enabled by defining SLFIFO_PROTO_CHECK_EN (adds proto_err).
module slave_fifo_responder
  import slave_fifo_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_WORDS  = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SLOE,
  input  logic                  SLRD,
  input  logic                  SLWR,
  input  logic [1:0]            FIFOADR,
  input  logic                  PKTEND,
  inout  wire  [15:0]           FD,
  output logic                  FLAG_EMPTY,
  output logic                  FLAG_FULL,
  input  logic                  host_wr_en,
  input  logic [15:0]           host_wr_data,
  input  logic                  host_rd_en,
  output logic [15:0]           host_rd_data,
  output logic                  host_rd_valid,
  output logic [DEPTH_LOG2:0]   host_in_avail
`ifdef SLFIFO_PROTO_CHECK_EN
  ,
  output logic                  proto_err
`endif
);
  localparam int CW = DEPTH_LOG2 + 1;

  logic [15:0]   out_head;
  logic [CW-1:0] out_count;
  logic [15:0]   in_head;
  logic [CW-1:0] in_count;
  logic [CW-1:0] uncommitted;
  logic [CW-1:0] u_after;
  logic          out_pop;
  logic          in_wr;
  logic          host_pop;
  logic          commit;
  logic          fd_oe;

  assign out_pop  = SLRD && (FIFOADR == SLFIFO_ADR_OUT);
  assign in_wr    = SLWR && (FIFOADR == SLFIFO_ADR_IN) && !FLAG_FULL;
  assign host_pop = host_rd_en && (host_in_avail != '0);

  // The write on this edge is counted before deciding whether the packet closes.
  assign u_after  = uncommitted + CW'(in_wr);
  assign commit   = (u_after == CW'(PKT_WORDS)) || (PKTEND && (u_after != '0));

  assign FLAG_EMPTY = (out_count == '0);
  assign FLAG_FULL  = (in_count == CW'(1 << DEPTH_LOG2));

  assign fd_oe = RST && SLOE && (FIFOADR == SLFIFO_ADR_OUT);
  assign FD    = fd_oe ? (FLAG_EMPTY ? 16'h0000 : out_head) : 16'hzzzz;

  sync_fifo_w16 #(.DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (host_wr_en),
    .push_data (host_wr_data),
    .pop       (out_pop),
    .head      (out_head),
    .count     (out_count)
  );

  sync_fifo_w16 #(.DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (in_wr),
    .push_data (FD),
    .pop       (host_pop),
    .head      (in_head),
    .count     (in_count)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      uncommitted   <= '0;
      host_in_avail <= '0;
      host_rd_data  <= '0;
      host_rd_valid <= 1'b0;
    end else begin
      uncommitted   <= commit ? '0 : u_after;
      host_in_avail <= host_in_avail - CW'(host_pop) + (commit ? u_after : '0);
      host_rd_valid <= host_pop;
      if (host_pop) host_rd_data <= in_head;
    end
  end

`ifdef SLFIFO_PROTO_CHECK_EN
  logic proto_hit;
  assign proto_hit = (SLWR && FLAG_FULL) || (SLRD && FLAG_EMPTY) || (SLRD && !SLOE) ||
                     (SLWR && SLOE) || (SLRD && (FIFOADR != SLFIFO_ADR_OUT)) ||
                     (SLWR && (FIFOADR != SLFIFO_ADR_IN)) || (SLRD && SLWR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           proto_err <= 1'b0;
    else if (proto_hit) proto_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_slave_fifo_responder.sv
// Self-checking bench for slave_fifo_responder: vector table, directed corner sequences, random traffic vs queue model.
module tb_slave_fifo_responder;
  localparam int DL    = 9;
  localparam int PKT   = 256;
  localparam int DEPTH = 512;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          SLOE = 1'b0, SLRD = 1'b0, SLWR = 1'b0, PKTEND = 1'b0;
  logic [1:0]    FIFOADR = 2'b00;
  wire  [15:0]   FD;
  logic [15:0]   tb_fd = 16'h0;
  logic          tb_fd_oe = 1'b0;
  logic          FLAG_EMPTY, FLAG_FULL;
  logic          host_wr_en = 1'b0, host_rd_en = 1'b0;
  logic [15:0]   host_wr_data = 16'h0;
  logic [15:0]   host_rd_data;
  logic          host_rd_valid;
  logic [DL:0]   host_in_avail;
`ifdef SLFIFO_PROTO_CHECK_EN
  logic          proto_err;
  logic          exp_perr = 1'b0;
`endif

  assign FD = tb_fd_oe ? tb_fd : 16'hzzzz;
  always #5 CLK = ~CLK;

  slave_fifo_responder #(.DEPTH_LOG2(DL), .PKT_WORDS(PKT)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SLOE          (SLOE),
    .SLRD          (SLRD),
    .SLWR          (SLWR),
    .FIFOADR       (FIFOADR),
    .PKTEND        (PKTEND),
    .FD            (FD),
    .FLAG_EMPTY    (FLAG_EMPTY),
    .FLAG_FULL     (FLAG_FULL),
    .host_wr_en    (host_wr_en),
    .host_wr_data  (host_wr_data),
    .host_rd_en    (host_rd_en),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .host_in_avail (host_in_avail)
`ifdef SLFIFO_PROTO_CHECK_EN
    ,
    .proto_err     (proto_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: OUT queue, uncommitted and committed IN queues.
  logic [15:0] out_q[$];
  logic [15:0] unc_q[$];
  logic [15:0] com_q[$];
  logic        exp_valid = 1'b0;
  logic [15:0] exp_data  = 16'h0;

  typedef struct {
    logic        sloe, slrd, slwr;
    logic [1:0]  adr;
    logic        pktend;
    logic [15:0] fdw;
    logic        hwe;
    logic [15:0] hwd;
    logic        hre;
    logic        exp_empty;
    logic [15:0] exp_fd;
    int          exp_avail;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic en;
    en = RST && SLOE && (FIFOADR == 2'b00);
    chk("flag_empty", FLAG_EMPTY, out_q.size() == 0);
    chk("flag_full", FLAG_FULL, (unc_q.size() + com_q.size()) == DEPTH);
    chk("in_avail", host_in_avail, com_q.size());
    chk("rd_valid", host_rd_valid, exp_valid);
    if (exp_valid) chk("rd_data", host_rd_data, exp_data);
    chk("fd_drive", dut.fd_oe, en);
    if (en) chk("fd", FD, (out_q.size() != 0) ? out_q[0] : 16'h0000);
`ifdef SLFIFO_PROTO_CHECK_EN
    chk("proto_err", proto_err, exp_perr);
`endif
  endtask

  task automatic step(input logic sloe, input logic slrd, input logic slwr, input logic [1:0] adr,
                      input logic pktend, input logic [15:0] fdw, input logic hwe,
                      input logic [15:0] hwd, input logic hre);
    int  osz;
    bit  full, empty;
    SLOE = sloe; SLRD = slrd; SLWR = slwr; FIFOADR = adr; PKTEND = pktend;
    tb_fd = fdw; tb_fd_oe = !(sloe && adr == 2'b00);
    host_wr_en = hwe; host_wr_data = hwd; host_rd_en = hre;
    osz   = out_q.size();
    full  = (unc_q.size() + com_q.size()) == DEPTH;
    empty = (osz == 0);
`ifdef SLFIFO_PROTO_CHECK_EN
    if ((slwr && full) || (slrd && empty) || (slrd && !sloe) || (slwr && sloe) ||
        (slrd && adr != 2'b00) || (slwr && adr != 2'b10) || (slrd && slwr))
      exp_perr = 1'b1;
`endif
    if (slrd && adr == 2'b00 && !empty) void'(out_q.pop_front());
    if (hwe && osz < DEPTH) out_q.push_back(hwd);
    exp_valid = 1'b0;
    if (hre && com_q.size() > 0) begin
      exp_valid = 1'b1;
      exp_data  = com_q.pop_front();
    end
    if (slwr && adr == 2'b10 && !full) unc_q.push_back(fdw);
    if (unc_q.size() == PKT || (pktend && unc_q.size() > 0)) begin
      foreach (unc_q[k]) com_q.push_back(unc_q[k]);
      unc_q.delete();
    end
    @(posedge CLK); #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h55AA, 1'b0, 1'b0, 16'h55AA, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h0123, 1'b0, 1'b0, 16'h55AA, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0123, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 2};

    #1;
    check_outputs();
    chk("rst_rd_data", host_rd_data, 16'h0000);
    @(posedge CLK); #1;
    RST = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].sloe, tbl[i].slrd, tbl[i].slwr, tbl[i].adr, tbl[i].pktend, tbl[i].fdw,
           tbl[i].hwe, tbl[i].hwd, tbl[i].hre);
      chk($sformatf("tbl%0d_empty", i), FLAG_EMPTY, tbl[i].exp_empty);
      chk($sformatf("tbl%0d_avail", i), host_in_avail, tbl[i].exp_avail);
      if (tbl[i].sloe && tbl[i].adr == 2'b00) chk($sformatf("tbl%0d_fd", i), FD, tbl[i].exp_fd);
    end
    chk("tbl_rd_data", host_rd_data, 16'h1111);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // Full packet auto-commit on the 256th write, then drain in order.
    for (int i = 0; i < PKT; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'(i), 1'b0, 16'h0, 1'b0);
      if (i == PKT - 2) chk("pkt_avail_before", host_in_avail, 0);
      if (i == PKT - 1) chk("pkt_avail_after", host_in_avail, PKT);
    end
    for (int i = 0; i < PKT; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      chk("drain_word", host_rd_data, 16'(i));
    end
    idle();

    // Reset mid-packet discards uncommitted IN data and buffered OUT data.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'(i + 16'h0A00), i < 5, 16'(i + 100), 1'b0);
    SLWR = 1'b0; host_wr_en = 1'b0; SLOE = 1'b1; FIFOADR = 2'b00; tb_fd_oe = 1'b0;
    RST = 1'b0;
    out_q.delete(); unc_q.delete(); com_q.delete(); exp_valid = 1'b0;
`ifdef SLFIFO_PROTO_CHECK_EN
    exp_perr = 1'b0;
`endif
    #1;
    chk("rst_mid_empty", FLAG_EMPTY, 1'b1);
    chk("rst_mid_avail", host_in_avail, 0);
    chk("rst_mid_fd_z", dut.fd_oe, 1'b0);
    check_outputs();
    @(posedge CLK); #1;
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("rst_pktend_avail", host_in_avail, 0);

    // Fill IN to capacity, overflow write dropped, one host read frees space.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'(i ^ 16'hA5A5), 1'b0, 16'h0, 1'b0);
      if (i == DEPTH - 2) chk("fill_full_early", FLAG_FULL, 1'b0);
    end
    chk("fill_full", FLAG_FULL, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    chk("overflow_avail", host_in_avail, DEPTH);
`ifdef SLFIFO_PROTO_CHECK_EN
    chk("overflow_proto", proto_err, 1'b1);
`endif
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("after_read_full", FLAG_FULL, 1'b0);
    chk("after_read_data", host_rd_data, 16'hA5A5);

    // Simultaneous host push and SLRD pop with one word buffered.
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b1, 16'hC0DE, 1'b0);
    chk("pushpop_empty", FLAG_EMPTY, 1'b0);
    chk("pushpop_fd", FD, 16'hC0DE);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("pushpop_drained", FLAG_EMPTY, 1'b1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic       r_sloe, r_rd, r_wr;
      logic [1:0] r_adr;
      r_wr = ($urandom_range(0, 2) == 0);
      r_rd = !r_wr && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) r_adr = 2'($urandom_range(0, 3));
      else                            r_adr = r_wr ? 2'b10 : 2'b00;
      r_sloe = r_wr ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      step(r_sloe, r_rd, r_wr, r_adr, $urandom_range(0, 15) == 0, 16'($urandom),
           $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 1) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
